// File: rtl/counter4bit.sv
// Up/down counter: synchronous active-high reset, count enable and direction select.
// The count output comes straight from the state register.
module counter4bit #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             count_dir,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next value: hold unless enabled; modular +/-1 wraps naturally at the width
    always_comb begin
        count_d = count_q;
        if (enable) begin
            count_d = count_dir ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_counter4bit.sv
// Self-checking bench for counter4bit: vector table, directed corner sequences
// and randomized stimulus against an arithmetic reference model.
module tb_counter4bit;

    localparam int unsigned WIDTH = 4;
    localparam int          MODV  = 16;

    logic             clk;
    logic             reset;
    logic             enable;
    logic             count_dir;
    logic [WIDTH-1:0] count;

    int total;
    int bad;
    int model;

    typedef struct {
        logic  r;
        logic  e;
        logic  d;
        int    exp;
        string name;
    } vec_t;

    vec_t tbl[$];

    counter4bit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .count_dir (count_dir),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: count=%0d expected=%0d at %0t", name, got, exp, $time);
        end
    endtask

    // Drive inputs at the falling edge, cross one rising edge, check at the next falling edge.
    // exp < 0 means compare against the reference model only.
    task automatic step(input logic r, input logic e, input logic d, input string name,
                        input int exp = -1);
        reset     = r;
        enable    = e;
        count_dir = d;
        @(posedge clk);
        if (r)      model = 0;
        else if (e) model = d ? (model + 1) % MODV : (model + MODV - 1) % MODV;
        @(negedge clk);
        check(name, int'(count), (exp >= 0) ? exp : model);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        model     = 0;
        reset     = 1'b0;
        enable    = 1'b0;
        count_dir = 1'b0;
        @(negedge clk);

        // Reset, then hold reset while enabled, up-count with wrap, then down-wrap
        tbl.push_back('{1'b1, 1'b0, 1'b0, 0, "reset_en0"});
        for (int i = 0; i < 3; i++) tbl.push_back('{1'b1, 1'b1, 1'b1, 0, "reset_hold_en1"});
        for (int i = 1; i <= 16; i++) tbl.push_back('{1'b0, 1'b1, 1'b1, i % MODV, "up_count"});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 15, "down_wrap_from_0"});
        foreach (tbl[i]) step(tbl[i].r, tbl[i].e, tbl[i].d, tbl[i].name, tbl[i].exp);

        // Down count 15 -> 0 then wrap to 15
        for (int v = 14; v >= 0; v--) step(1'b0, 1'b1, 1'b0, "down_count", v);
        step(1'b0, 1'b1, 1'b0, "down_wrap", 15);

        // Hold at 7 with direction toggling, then resume up
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, "to_7");
        check("at_7", int'(count), 7);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, logic'(i[0]), "hold_7", 7);
        step(1'b0, 1'b1, 1'b1, "resume_up_8", 8);

        // Reset mid-count at 9, then resume from 0
        step(1'b1, 1'b0, 1'b0, "reset_pre", 0);
        for (int i = 1; i <= 9; i++) step(1'b0, 1'b1, 1'b1, "up_to_9", i);
        step(1'b1, 1'b1, 1'b1, "reset_mid", 0);
        step(1'b0, 1'b1, 1'b1, "resume_after_reset", 1);

        // Direction reversal at 5
        for (int i = 2; i <= 5; i++) step(1'b0, 1'b1, 1'b1, "up_to_5", i);
        step(1'b0, 1'b1, 1'b0, "reverse_4", 4);
        step(1'b0, 1'b1, 1'b0, "reverse_3", 3);

        // Enable glitch between edges, low at the edge: must hold
        enable = 1'b1; count_dir = 1'b1;
        #2 enable = 1'b0;
        #1 enable = 1'b1;
        #1 enable = 1'b0;
        step(1'b0, 1'b0, 1'b1, "glitch_hold", 3);

        // Reset asserted between edges must not act before the rising edge
        reset = 1'b1;
        #2 check("reset_async_none", int'(count), 3);
        step(1'b1, 1'b0, 1'b0, "reset_at_edge", 0);

        // Randomized stimulus against the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) == 0), 1'($urandom), 1'($urandom), "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
